// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle RV32I controller
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10,
      FAULT    = 4'd11
   } state_e;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_READDATA  = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic [1:0] imm_sel(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_BEQ:  return IMM_B;
         OP_JAL:  return IMM_J;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_alu_decoder.sv
// rtl/ctrl_alu_decoder.sv - combinational alu_op/funct decode to alu_control
module ctrl_alu_decoder
   import ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // only R-type sub sets bit 30; addi reuses that bit as immediate
               3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I sequencing FSM with memory timeout
// Define CTRL_PERF_CNT_EN to build the retired-instruction counter behind instret.
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = $clog2(MEM_TIMEOUT + 1),
   parameter int PERF_CNT_W  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [6:0]            op,
   input  logic [2:0]            funct3,
   input  logic                  funct7b5,
   input  logic                  zero,
   input  logic                  mem_ready,
   output logic                  mem_req,
   output logic                  mem_write,
   output logic                  adr_src,
   output logic                  ir_write,
   output logic                  pc_write,
   output logic                  reg_write,
   output logic [1:0]            result_src,
   output logic [1:0]            alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            imm_src,
   output logic [2:0]            alu_control,
   output logic                  fault,
   output logic [PERF_CNT_W-1:0] instret
);

   localparam int CNT_W = (TO_W > 0) ? TO_W : 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_q, wait_d;
   logic [1:0]       alu_op;
   logic             req_c, wr_c, irw_c, pcw_c, rw_c;
   logic             mem_wait, timeout_hit;

   assign mem_wait    = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
   assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_q == CNT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d    = state_q;
      req_c      = 1'b0;
      wr_c       = 1'b0;
      irw_c      = 1'b0;
      pcw_c      = 1'b0;
      rw_c       = 1'b0;
      adr_src    = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      case (state_q)
         FETCH: begin
            req_c      = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            if (mem_ready) begin
               irw_c   = 1'b1;
               pcw_c   = 1'b1;
               state_d = DECODE;
            end else if (timeout_hit) begin
               state_d = FAULT;
            end
         end
         DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECR;
               OP_ITYPE:     state_d = EXECI;
               OP_BEQ:       state_d = BEQ;
               OP_JAL:       state_d = JAL;
               default:      state_d = FAULT;
            endcase
         end
         MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = (op == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            req_c   = 1'b1;
            adr_src = 1'b1;
            if (mem_ready)        state_d = MEMWB;
            else if (timeout_hit) state_d = FAULT;
         end
         MEMWB: begin
            result_src = RES_READDATA;
            rw_c       = 1'b1;
            state_d    = FETCH;
         end
         MEMWRITE: begin
            req_c   = 1'b1;
            wr_c    = 1'b1;
            adr_src = 1'b1;
            if (mem_ready)        state_d = FETCH;
            else if (timeout_hit) state_d = FAULT;
         end
         EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_FUNCT;
            state_d   = ALUWB;
         end
         EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
            state_d   = ALUWB;
         end
         ALUWB: begin
            rw_c    = 1'b1;
            state_d = FETCH;
         end
         BEQ: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_SUB;
            pcw_c     = zero;
            state_d   = FETCH;
         end
         JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pcw_c     = 1'b1;
            state_d   = ALUWB;
         end
         FAULT:   state_d = FAULT;
         default: state_d = FAULT;
      endcase
   end

   // Counter restarts for every new access since any state change clears it
   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q)          wait_d = '0;
      else if (mem_wait && !mem_ready) wait_d = wait_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   ctrl_alu_decoder u_alu_dec (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .op5         (op[5]),
      .funct7b5    (funct7b5),
      .alu_control (alu_control)
   );

   // Strobes are held low during reset even though the state already reads FETCH
   assign mem_req   = req_c & rst_n;
   assign mem_write = wr_c & rst_n;
   assign ir_write  = irw_c & rst_n;
   assign pc_write  = pcw_c & rst_n;
   assign reg_write = rw_c & rst_n;
   assign imm_src   = imm_sel(op);
   assign fault     = (state_q == FAULT);

`ifdef CTRL_PERF_CNT_EN
   logic                  retire;
   logic [PERF_CNT_W-1:0] instret_q, instret_d;

   assign retire = (state_d == FETCH) &&
                   ((state_q == ALUWB) || (state_q == MEMWB) ||
                    (state_q == MEMWRITE) || (state_q == BEQ));

   always_comb begin
      instret_d = instret_q + PERF_CNT_W'(retire);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) instret_q <= '0;
      else        instret_q <= instret_d;
   end

   assign instret = instret_q;
`else
   assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed scoreboard bench for multicycle_controller
module tb_multicycle_controller;

   typedef logic [17:0] ovec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7b5, zero, mem_ready;
   logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, fault;
   logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0]  alu_control;
   logic [31:0] instret;
   ovec_t       obs;

   ovec_t exp_q[$];
   string tag_q[$];
   int    n_chk = 0;
   int    n_fail = 0;
   int    n_ret = 0;

   multicycle_controller #(.MEM_TIMEOUT(4), .PERF_CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
      .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .imm_src(imm_src), .alu_control(alu_control), .fault(fault), .instret(instret)
   );

   always #5 clk = ~clk;

   assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 result_src, alu_src_a, alu_src_b, imm_src, alu_control, fault};

   function automatic logic [1:0] e_imm(input logic [6:0] o);
      case (o)
         7'b0100011: return 2'b01;
         7'b1100011: return 2'b10;
         7'b1101111: return 2'b11;
         default:    return 2'b00;
      endcase
   endfunction

   function automatic logic [2:0] e_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic ovec_t mk(input logic req, wr, adr, irw, pcw, rw,
                                input logic [1:0] rs, sa, sb,
                                input logic [2:0] ac, input logic flt);
      return {req, wr, adr, irw, pcw, rw, rs, sa, sb, e_imm(op), ac, flt};
   endfunction

   function automatic ovec_t v_fetch(input logic r);
      return mk(1, 0, 0, r, r, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0);
   endfunction
   function automatic ovec_t v_decode();   return mk(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 0); endfunction
   function automatic ovec_t v_memadr();   return mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 0); endfunction
   function automatic ovec_t v_memread();  return mk(1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 0); endfunction
   function automatic ovec_t v_memwb();    return mk(0,0,0,0,0,1, 2'b01, 2'b00, 2'b00, 3'b000, 0); endfunction
   function automatic ovec_t v_memwrite(); return mk(1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 0); endfunction
   function automatic ovec_t v_aluwb();    return mk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 0); endfunction
   function automatic ovec_t v_jal();      return mk(0,0,0,0,1,0, 2'b00, 2'b01, 2'b10, 3'b000, 0); endfunction
   function automatic ovec_t v_fault();    return mk(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 1); endfunction
   function automatic ovec_t v_reset();    return mk(0,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'b000, 0); endfunction
   function automatic ovec_t v_beq(input logic z);
      return mk(0, 0, 0, 0, z, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);
   endfunction
   function automatic ovec_t v_exec(input logic imm);
      return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, imm ? 2'b01 : 2'b00, e_alu(op, funct3, funct7b5), 0);
   endfunction

   task automatic check_out();
      ovec_t e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_chk++;
      assert (obs === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
   endtask

   task automatic chk_now(input string t, input ovec_t e);
      exp_q.push_back(e);
      tag_q.push_back(t);
      #1;
      check_out();
   endtask

   task automatic cyc(input string t, input ovec_t e, input logic rdy, input logic z);
      mem_ready = rdy;
      zero      = z;
      chk_now(t, e);
      @(negedge clk);
   endtask

   task automatic chk_ret(input string t);
      logic [31:0] e;
`ifdef CTRL_PERF_CNT_EN
      e = 32'(n_ret);
`else
      e = 32'd0;
`endif
      n_chk++;
      assert (instret === e) else begin
         n_fail++;
         $error("FAIL %s: observed instret %0d expected %0d", t, instret, e);
      end
   endtask

   task automatic set_ins(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      op = o; funct3 = f3; funct7b5 = f7;
   endtask

   task automatic do_alu(input string t, input logic [6:0] o, input logic [2:0] f3, input logic f7);
      set_ins(o, f3, f7);
      cyc({t, "_fetch"},  v_fetch(1'b1), 1'b1, 1'b0);
      cyc({t, "_decode"}, v_decode(),    1'b1, 1'b0);
      cyc({t, "_exec"},   v_exec(o == 7'b0010011), 1'b1, 1'b0);
      cyc({t, "_wb"},     v_aluwb(),     1'b1, 1'b0);
      n_ret++;
      chk_ret({t, "_instret"});
   endtask

   task automatic do_reset(input string t);
      rst_n = 1'b0;
      chk_now({t, "_in_reset"}, v_reset());
      n_ret = 0;
      chk_ret({t, "_instret_clr"});
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      set_ins(7'b0, 3'b0, 1'b0);
      zero = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      chk_now("reset_outputs", v_reset());
      chk_ret("reset_instret");
      rst_n = 1'b1;

      do_alu("add",  7'b0110011, 3'b000, 1'b0);
      do_alu("sub",  7'b0110011, 3'b000, 1'b1);
      do_alu("and",  7'b0110011, 3'b111, 1'b0);
      do_alu("sll",  7'b0110011, 3'b001, 1'b0);
      do_alu("addi", 7'b0010011, 3'b000, 1'b1);
      do_alu("slti", 7'b0010011, 3'b010, 1'b0);
      do_alu("ori",  7'b0010011, 3'b110, 1'b0);

      set_ins(7'b0000011, 3'b010, 1'b0);
      cyc("lw_fetch",  v_fetch(1'b1), 1'b1, 1'b0);
      cyc("lw_decode", v_decode(),    1'b1, 1'b0);
      cyc("lw_memadr", v_memadr(),    1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc("lw_memread_wait", v_memread(), 1'b0, 1'b0);
      cyc("lw_memread_done", v_memread(), 1'b1, 1'b0);
      cyc("lw_memwb", v_memwb(), 1'b1, 1'b0);
      n_ret++;
      chk_ret("lw_instret");

      set_ins(7'b0100011, 3'b010, 1'b0);
      cyc("sw_fetch",    v_fetch(1'b1), 1'b1, 1'b0);
      cyc("sw_decode",   v_decode(),    1'b1, 1'b0);
      cyc("sw_memadr",   v_memadr(),    1'b1, 1'b0);
      cyc("sw_memwrite", v_memwrite(),  1'b1, 1'b0);
      n_ret++;
      chk_ret("sw_instret");

      set_ins(7'b1100011, 3'b000, 1'b0);
      cyc("beq1_fetch",  v_fetch(1'b1), 1'b1, 1'b1);
      cyc("beq1_decode", v_decode(),    1'b1, 1'b1);
      cyc("beq1_taken",  v_beq(1'b1),   1'b1, 1'b1);
      n_ret++;
      cyc("beq2_fetch",  v_fetch(1'b1), 1'b1, 1'b0);
      cyc("beq2_decode", v_decode(),    1'b1, 1'b0);
      cyc("beq2_not",    v_beq(1'b0),   1'b1, 1'b0);
      n_ret++;
      chk_ret("beq_instret");

      set_ins(7'b1101111, 3'b000, 1'b0);
      cyc("jal_fetch",  v_fetch(1'b1), 1'b1, 1'b0);
      cyc("jal_decode", v_decode(),    1'b1, 1'b0);
      cyc("jal_jal",    v_jal(),       1'b1, 1'b0);
      cyc("jal_wb",     v_aluwb(),     1'b1, 1'b0);
      n_ret++;
      chk_ret("jal_instret");

      // ready arrives on the last allowed wait cycle
      set_ins(7'b0110011, 3'b000, 1'b0);
      for (int i = 0; i < 3; i++) cyc("late_fetch_wait", v_fetch(1'b0), 1'b0, 1'b0);
      cyc("late_fetch_done", v_fetch(1'b1), 1'b1, 1'b0);
      cyc("late_decode",     v_decode(),    1'b1, 1'b0);
      cyc("late_exec",       v_exec(1'b0),  1'b1, 1'b0);
      cyc("late_wb",         v_aluwb(),     1'b1, 1'b0);
      n_ret++;
      chk_ret("late_instret");

      for (int i = 0; i < 4; i++) cyc("tmo_fetch_wait", v_fetch(1'b0), 1'b0, 1'b0);
      cyc("tmo_fault",        v_fault(), 1'b1, 1'b1);
      cyc("tmo_fault_sticky", v_fault(), 1'b1, 1'b1);
      chk_ret("tmo_instret");
      do_reset("tmo");

      set_ins(7'b1111111, 3'b000, 1'b0);
      cyc("ill_fetch",  v_fetch(1'b1), 1'b1, 1'b0);
      cyc("ill_decode", v_decode(),    1'b1, 1'b0);
      cyc("ill_fault",  v_fault(),     1'b1, 1'b0);
      do_reset("ill");

      set_ins(7'b0100011, 3'b010, 1'b0);
      cyc("rsw_fetch",  v_fetch(1'b1), 1'b1, 1'b0);
      cyc("rsw_decode", v_decode(),    1'b1, 1'b0);
      cyc("rsw_memadr", v_memadr(),    1'b1, 1'b0);
      mem_ready = 1'b0;
      chk_now("rsw_memwrite", v_memwrite());
      #1;
      do_reset("rsw");
      set_ins(7'b0110011, 3'b000, 1'b0);
      cyc("post_fetch", v_fetch(1'b1), 1'b1, 1'b0);
      cyc("post_decode", v_decode(),   1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
